// File: rtl/soc_wb_mailbox_pkg.sv
// Shared constants for the Wishbone byte-stream mailbox: register offsets,
// CSR bit positions and the value returned when the CPU reads an empty RX FIFO.
package soc_wb_mailbox_pkg;

    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;

    localparam int CSR_TX_EMPTY = 0;
    localparam int CSR_TX_FULL  = 1;
    localparam int CSR_RX_EMPTY = 2;
    localparam int CSR_RX_FULL  = 3;
    localparam int CSR_TX_OVF   = 4;

    localparam int CSR_FLUSH_TX = 0;
    localparam int CSR_FLUSH_RX = 1;
    localparam int CSR_CLR_OVF  = 4;

    localparam int LVL_TX_LSB = 16;
    localparam int LVL_RX_LSB = 24;

    localparam logic [31:0] EMPTY_READ = 32'h8000_0000;

endpackage

// File: rtl/fifo_sync_lvl.sv
// Synchronous first-word-fall-through FIFO with a level counter and flush.
// Full/empty gating uses the state before the cycle; flush overrides push and pop.
module fifo_sync_lvl #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic          flush,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Head is masked while empty so the output is a defined 0 out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(do_wr) - LW'(do_rd);
        end
    end

endmodule

// File: rtl/soc_wb_mailbox.sv
// Wishbone responder exposing a TX and an RX byte FIFO to the CPU. Every access
// is acked one cycle after cyc rises, and all side effects commit in that ack cycle.
module soc_wb_mailbox
    import soc_wb_mailbox_pkg::*;
#(
    parameter int WB_AW      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WB_AW-1:0] wb_addr,
    output logic [31:0]      wb_rdata,
    input  logic [31:0]      wb_wdata,
    input  logic [3:0]       wb_wmsk,
    input  logic             wb_we,
    input  logic             wb_cyc,
    output logic             wb_ack,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready
);

    logic [1:0]    reg_sel;
    logic          acc;
    logic          wr_csr;
    logic          wr_dat;
    logic          rd_dat;
    logic          flush_tx;
    logic          flush_rx;
    logic          tx_ovf;
    logic          tx_empty;
    logic          tx_full;
    logic [LW-1:0] tx_level;
    logic          rx_empty;
    logic          rx_full;
    logic [LW-1:0] rx_level;
    logic [7:0]    rx_byte;
    logic [31:0]   csr_val;
    logic [31:0]   rd_val;
    logic          unused_bits;

    assign reg_sel  = wb_addr[1:0];
    assign acc      = wb_ack & wb_cyc;
    assign wr_csr   = acc & wb_we & wb_wmsk[0] & (reg_sel == REG_CSR);
    assign wr_dat   = acc & wb_we & wb_wmsk[0] & (reg_sel == REG_DATA);
    assign rd_dat   = acc & ~wb_we & (reg_sel == REG_DATA);
    assign flush_tx = wr_csr & wb_wdata[CSR_FLUSH_TX];
    assign flush_rx = wr_csr & wb_wdata[CSR_FLUSH_RX];

    assign unused_bits = ^{wb_addr[WB_AW-1:2], wb_wdata[31:8], wb_wmsk[3:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack <= 1'b0;
        end else begin
            wb_ack <= wb_cyc & ~wb_ack;
        end
    end

    // Overflow uses the pre-cycle full flag, so a same-cycle drain does not rescue the byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf <= 1'b0;
        end else if (wr_dat && tx_full) begin
            tx_ovf <= 1'b1;
        end else if (wr_csr && wb_wdata[CSR_CLR_OVF]) begin
            tx_ovf <= 1'b0;
        end
    end

    fifo_sync_lvl #(.W(8), .DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_dat),
        .wr_data (wb_wdata[7:0]),
        .rd_en   (tx_ready),
        .flush   (flush_tx),
        .rd_data (tx_data),
        .empty   (tx_empty),
        .full    (tx_full),
        .level   (tx_level)
    );

    fifo_sync_lvl #(.W(8), .DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_valid),
        .wr_data (rx_data),
        .rd_en   (rd_dat),
        .flush   (flush_rx),
        .rd_data (rx_byte),
        .empty   (rx_empty),
        .full    (rx_full),
        .level   (rx_level)
    );

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    always_comb begin
        csr_val                        = '0;
        csr_val[CSR_TX_EMPTY]          = tx_empty;
        csr_val[CSR_TX_FULL]           = tx_full;
        csr_val[CSR_RX_EMPTY]          = rx_empty;
        csr_val[CSR_RX_FULL]           = rx_full;
        csr_val[CSR_TX_OVF]            = tx_ovf;
        csr_val[LVL_TX_LSB +: LW]      = tx_level;
        csr_val[LVL_RX_LSB +: LW]      = rx_level;
    end

    // Read data is zero outside the ack cycle so slot outputs can be OR-combined.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_CSR:  rd_val = csr_val;
            REG_DATA: rd_val = rx_empty ? EMPTY_READ : {24'b0, rx_byte};
            default:  rd_val = '0;
        endcase
        wb_rdata = wb_ack ? rd_val : '0;
    end

endmodule

// File: tb/tb_soc_wb_mailbox.sv
// Directed bench for the Wishbone mailbox: CSR/DATA accesses, TX drain order,
// overflow, RX fill/drain, simultaneous capture+pop, flush and mid-access reset.
module tb_soc_wb_mailbox;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wb_addr;
    logic [31:0] wb_rdata;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_wmsk;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int vectors     = 0;
    int miscompares = 0;

    soc_wb_mailbox #(.WB_AW(16), .FIFO_DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_addr  (wb_addr),
        .wb_rdata (wb_rdata),
        .wb_wdata (wb_wdata),
        .wb_wmsk  (wb_wmsk),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called 1 ns after a rising edge; returns 1 ns after a rising edge with one idle cycle done.
    task automatic wb_access(input logic [1:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [3:0] msk, output logic [31:0] rdata);
        wb_addr  = {14'b0, addr};
        wb_we    = we;
        wb_wdata = wdata;
        wb_wmsk  = msk;
        wb_cyc   = 1'b1;
        @(posedge clk); #1;
        chk("ack_latency", {31'b0, wb_ack}, 32'd1);
        rdata = wb_rdata;
        @(posedge clk); #1;
        chk("ack_single", {31'b0, wb_ack}, 32'd0);
        chk("rdata_idle", wb_rdata, 32'd0);
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input logic [1:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        wb_access(addr, 1'b1, wdata, 4'b0001, dummy);
    endtask

    task automatic wb_read_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_access(addr, 1'b0, 32'd0, 4'b0000, rd);
        chk(tag, rd, exp);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        rst      = 1'b1;
        wb_addr  = '0;
        wb_wdata = '0;
        wb_wmsk  = '0;
        wb_we    = 1'b0;
        wb_cyc   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_ack", {31'b0, wb_ack}, 32'd0);
        chk("rst_rdata", wb_rdata, 32'd0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
        wb_read_chk("csr_reset", 2'd0, 32'h0000_0005);

        // Masked-off DATA write and unmapped register
        wb_access(2'd1, 1'b1, 32'h0000_0077, 4'b0010, rd);
        wb_read_chk("csr_masked_write", 2'd0, 32'h0000_0005);
        wb_write(2'd2, 32'hFFFF_FFFF);
        wb_read_chk("reg2_zero", 2'd2, 32'h0000_0000);

        // Three pushes, then drain in order
        wb_write(2'd1, 32'h41);
        chk("tx_valid_after_push", {31'b0, tx_valid}, 32'd1);
        wb_write(2'd1, 32'h42);
        wb_write(2'd1, 32'h43);
        wb_read_chk("csr_tx3", 2'd0, 32'h0003_0004);
        chk("tx_hold", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        chk("tx_drain0", {24'b0, tx_data}, 32'h41);
        @(posedge clk); #1;
        chk("tx_drain1", {24'b0, tx_data}, 32'h42);
        @(posedge clk); #1;
        chk("tx_drain2", {24'b0, tx_data}, 32'h43);
        @(posedge clk); #1;
        chk("tx_drained_valid", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Overflow: 17 pushes into depth 16
        for (int i = 0; i < 17; i++) begin
            wb_write(2'd1, 32'h50 + i);
        end
        wb_read_chk("csr_full_ovf", 2'd0, 32'h0010_0016);
        wb_write(2'd0, 32'h10);
        wb_read_chk("csr_ovf_clr", 2'd0, 32'h0010_0006);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("tx_ovf_drain", {24'b0, tx_data}, 32'h50 + i);
            @(posedge clk); #1;
        end
        chk("tx_17th_absent", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // RX fill to full, then CPU drain
        for (int i = 0; i < 16; i++) begin
            chk("rx_ready_fill", {31'b0, rx_ready}, 32'd1);
            rx_push(8'(i));
        end
        chk("rx_ready_full", {31'b0, rx_ready}, 32'd0);
        wb_read_chk("csr_rx_full", 2'd0, 32'h1000_0009);
        for (int i = 0; i < 16; i++) begin
            wb_read_chk("rx_read", 2'd1, 32'(i));
        end
        wb_read_chk("rx_read_empty", 2'd1, 32'h8000_0000);
        wb_read_chk("csr_rx_drained", 2'd0, 32'h0000_0005);

        // Capture and pop in the same cycle
        rx_push(8'hA0);
        rx_push(8'hA1);
        rx_push(8'hA2);
        wb_addr = 16'd1;
        wb_we   = 1'b0;
        wb_wmsk = 4'b0000;
        wb_cyc  = 1'b1;
        @(posedge clk); #1;
        chk("simul_ack", {31'b0, wb_ack}, 32'd1);
        chk("simul_rdata", wb_rdata, 32'h0000_00A0);
        rx_data  = 8'hB0;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        wb_cyc   = 1'b0;
        @(posedge clk); #1;
        wb_read_chk("csr_simul_level", 2'd0, 32'h0300_0001);
        wb_read_chk("simul_order0", 2'd1, 32'h0000_00A1);
        wb_read_chk("simul_order1", 2'd1, 32'h0000_00A2);
        wb_read_chk("simul_order2", 2'd1, 32'h0000_00B0);

        // Flush both FIFOs holding 5 bytes each
        for (int i = 0; i < 5; i++) begin
            wb_write(2'd1, 32'h60 + i);
            rx_push(8'h70 + 8'(i));
        end
        wb_read_chk("csr_pre_flush", 2'd0, 32'h0505_0000);
        wb_write(2'd0, 32'h3);
        wb_read_chk("csr_post_flush", 2'd0, 32'h0000_0005);
        chk("flush_tx_valid", {31'b0, tx_valid}, 32'd0);

        // Reset in the cycle cyc rises
        wb_write(2'd1, 32'h99);
        wb_addr = 16'd0;
        wb_we   = 1'b0;
        wb_cyc  = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ack", {31'b0, wb_ack}, 32'd0);
        chk("midrst_rdata", wb_rdata, 32'd0);
        chk("midrst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("midrst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("midrst_rx_ready", {31'b0, rx_ready}, 32'd1);
        wb_cyc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_ack", {31'b0, wb_ack}, 32'd0);
        wb_read_chk("csr_postrst", 2'd0, 32'h0000_0005);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
